// File: rtl/dmem_arbiter_if.sv
// Bundle of the core, external-requester and DataMemory signals around the data-memory arbiter.
// The slave modport is the arbiter's view. The master modport is the surrounding pipeline/memory view.
interface dmem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 17
);
    logic                  core_req;
    logic                  core_we;
    logic [2:0]            core_size;
    logic [ADDR_WIDTH-1:0] core_addr;
    logic [DATA_WIDTH-1:0] core_wdata;
    logic [DATA_WIDTH-1:0] core_rdata;
    logic                  core_stall;

    logic                  ext_valid;
    logic                  ext_ready;
    logic                  ext_we;
    logic [2:0]            ext_size;
    logic [ADDR_WIDTH-1:0] ext_addr;
    logic [DATA_WIDTH-1:0] ext_wdata;
    logic                  ext_rvalid;
    logic [DATA_WIDTH-1:0] ext_rdata;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_we;
    logic [2:0]            mem_size;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  core_req, core_we, core_size, core_addr, core_wdata,
        output core_rdata, core_stall,
        input  ext_valid, ext_we, ext_size, ext_addr, ext_wdata,
        output ext_ready, ext_rvalid, ext_rdata,
        output mem_addr, mem_wdata, mem_we, mem_size,
        input  mem_rdata
    );

    modport master (
        output core_req, core_we, core_size, core_addr, core_wdata,
        input  core_rdata, core_stall,
        output ext_valid, ext_we, ext_size, ext_addr, ext_wdata,
        input  ext_ready, ext_rvalid, ext_rdata,
        input  mem_addr, mem_wdata, mem_we, mem_size,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the DataMemory port between the MEM stage (priority) and an external requester.
// A saturating wait counter bounds external starvation to MAX_WAIT consecutive core wins.
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 17,
    parameter int MAX_WAIT   = 4
) (
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave bus
);
    localparam int              WW       = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0]   WAIT_MAX = WW'(MAX_WAIT);

    generate
        if (MAX_WAIT < 1) begin : g_bad_max_wait
            $error("dmem_arbiter: MAX_WAIT must be >= 1");
        end
    endgenerate

    logic                  grant_ext;
    logic                  grant_core;
    logic                  wait_full;
    logic [WW-1:0]         wait_cnt;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [2:0]            sel_size;
    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    // Gating with rst keeps every grant, and so mem_we, low for the whole reset window.
    always_comb begin
        wait_full  = (wait_cnt == WAIT_MAX);
        grant_ext  = rst & bus.ext_valid & (~bus.core_req | wait_full);
        grant_core = rst & bus.core_req & ~grant_ext;
        sel_addr   = grant_ext ? bus.ext_addr  : bus.core_addr;
        sel_wdata  = grant_ext ? bus.ext_wdata : bus.core_wdata;
        sel_size   = grant_ext ? bus.ext_size  : bus.core_size;
    end

    assign bus.mem_addr   = sel_addr;
    assign bus.mem_wdata  = sel_wdata;
    assign bus.mem_size   = sel_size;
    assign bus.mem_we     = (grant_core & bus.core_we) | (grant_ext & bus.ext_we);
    assign bus.core_rdata = bus.mem_rdata;
    assign bus.core_stall = bus.core_req & grant_ext;
    assign bus.ext_ready  = grant_ext;
    assign bus.ext_rvalid = rvalid_q;
    assign bus.ext_rdata  = rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            if (grant_ext || !bus.ext_valid) begin
                wait_cnt <= '0;
            end else if (grant_core && !wait_full) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            rvalid_q <= grant_ext & ~bus.ext_we;
            if (grant_ext && !bus.ext_we) begin
                rdata_q <= bus.mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: grant/mux vector table plus multi-cycle sequences.
// A small word-addressed memory behind the arbiter supplies combinational read data.
module tb_dmem_arbiter;
    localparam int DW = 32;
    localparam int AW = 17;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    dmem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WAIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DW-1:0] mem [256];

    always_comb bus.mem_rdata = mem[bus.mem_addr[9:2]];

    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic creq;
        logic cwe;
        logic evalid;
        logic ewe;
        logic exp_stall;
        logic exp_ready;
        logic exp_we;
        logic exp_ext_addr;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic creq, input logic cwe, input logic [AW-1:0] caddr,
                         input logic [DW-1:0] cwdata, input logic evalid, input logic ewe,
                         input logic [AW-1:0] eaddr, input logic [DW-1:0] ewdata);
        bus.core_req   = creq;
        bus.core_we    = cwe;
        bus.core_size  = 3'b010;
        bus.core_addr  = caddr;
        bus.core_wdata = cwdata;
        bus.ext_valid  = evalid;
        bus.ext_we     = ewe;
        bus.ext_size   = 3'b010;
        bus.ext_addr   = eaddr;
        bus.ext_wdata  = ewdata;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 17'h0, 32'h0, 1'b0, 1'b0, 17'h0, 32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        // reset holds every grant low even with both sides requesting
        rst = 1'b0;
        drive(1'b1, 1'b1, 17'h100, 32'h1, 1'b1, 1'b1, 17'h40, 32'h2);
        @(negedge clk);
        chk("rst_mem_we",     32'(bus.mem_we),     32'd0);
        chk("rst_ext_ready",  32'(bus.ext_ready),  32'd0);
        chk("rst_core_stall", 32'(bus.core_stall), 32'd0);
        chk("rst_ext_rvalid", 32'(bus.ext_rvalid), 32'd0);
        next_cycle();
        idle();
        rst = 1'b1;
        next_cycle();

        // vector table; an idle cycle between entries keeps the wait counter at zero
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].creq, vecs[i].cwe, 17'h010, 32'hA5A5_0000 + 32'(i),
                  vecs[i].evalid, vecs[i].ewe, 17'h020, 32'h5A5A_0000 + 32'(i));
            @(negedge clk);
            chk($sformatf("vec%0d_stall", i), 32'(bus.core_stall), 32'(vecs[i].exp_stall));
            chk($sformatf("vec%0d_ready", i), 32'(bus.ext_ready),  32'(vecs[i].exp_ready));
            chk($sformatf("vec%0d_we", i),    32'(bus.mem_we),     32'(vecs[i].exp_we));
            chk($sformatf("vec%0d_addr", i),  32'(bus.mem_addr),
                vecs[i].exp_ext_addr ? 32'h020 : 32'h010);
            next_cycle();
            idle();
            next_cycle();
        end

        // core write then core read back
        drive(1'b1, 1'b1, 17'h100, 32'hDEAD_BEEF, 1'b0, 1'b0, 17'h0, 32'h0);
        @(negedge clk);
        chk("cw_mem_we",  32'(bus.mem_we),     32'd1);
        chk("cw_stall",   32'(bus.core_stall), 32'd0);
        chk("cw_wdata",   bus.mem_wdata,       32'hDEAD_BEEF);
        next_cycle();
        drive(1'b1, 1'b0, 17'h100, 32'h0, 1'b0, 1'b0, 17'h0, 32'h0);
        @(negedge clk);
        chk("cr_rdata",   bus.core_rdata,      32'hDEAD_BEEF);
        chk("cr_mem_we",  32'(bus.mem_we),     32'd0);
        next_cycle();

        // ext write 0x040, then ext read with one-cycle response
        drive(1'b0, 1'b0, 17'h0, 32'h0, 1'b1, 1'b1, 17'h040, 32'h1234_5678);
        @(negedge clk);
        chk("ew_ready",   32'(bus.ext_ready),  32'd1);
        next_cycle();
        drive(1'b0, 1'b0, 17'h0, 32'h0, 1'b1, 1'b0, 17'h040, 32'h0);
        @(negedge clk);
        chk("er_ready",   32'(bus.ext_ready),  32'd1);
        chk("er_rvalid0", 32'(bus.ext_rvalid), 32'd0);
        next_cycle();
        idle();
        @(negedge clk);
        chk("er_rvalid1", 32'(bus.ext_rvalid), 32'd1);
        chk("er_rdata1",  bus.ext_rdata,       32'h1234_5678);
        next_cycle();
        @(negedge clk);
        chk("er_rvalid2", 32'(bus.ext_rvalid), 32'd0);
        chk("er_rdata_hold", bus.ext_rdata,    32'h1234_5678);
        next_cycle();

        // continuous contention: four core grants then one ext grant, repeating
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 17'h100, 32'h0, 1'b1, 1'b1, 17'h300, 32'h0000_0300);
            @(negedge clk);
            chk($sformatf("fair%0d_ready", i), 32'(bus.ext_ready),  (i % 5 == 4) ? 32'd1 : 32'd0);
            chk($sformatf("fair%0d_stall", i), 32'(bus.core_stall), (i % 5 == 4) ? 32'd1 : 32'd0);
            next_cycle();
        end
        idle();
        next_cycle();

        // core write 0x200 old value, then ext write vs core read of the same word
        drive(1'b1, 1'b1, 17'h200, 32'h1111_1111, 1'b0, 1'b0, 17'h0, 32'h0);
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 17'h200, 32'h0, 1'b1, 1'b1, 17'h200, 32'hCAFE_F00D);
            @(negedge clk);
            chk($sformatf("cont%0d_rdata_old", i), bus.core_rdata, 32'h1111_1111);
            next_cycle();
        end
        @(negedge clk);
        chk("cont_stall",  32'(bus.core_stall), 32'd1);
        chk("cont_ready",  32'(bus.ext_ready),  32'd1);
        chk("cont_mem_we", 32'(bus.mem_we),     32'd1);
        next_cycle();
        drive(1'b1, 1'b0, 17'h200, 32'h0, 1'b0, 1'b0, 17'h0, 32'h0);
        @(negedge clk);
        chk("cont_after_stall", 32'(bus.core_stall), 32'd0);
        chk("cont_after_rdata", bus.core_rdata,      32'hCAFE_F00D);
        next_cycle();
        idle();
        next_cycle();

        // reset asserted right after an ext read handshake
        drive(1'b0, 1'b0, 17'h0, 32'h0, 1'b1, 1'b0, 17'h040, 32'h0);
        @(negedge clk);
        chk("rr_ready", 32'(bus.ext_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, 1'b0, 17'h100, 32'h0, 1'b1, 1'b1, 17'h040, 32'h0);
        #1;
        chk("rr_rvalid_dropped", 32'(bus.ext_rvalid), 32'd0);
        @(negedge clk);
        chk("rr_mem_we",  32'(bus.mem_we),     32'd0);
        chk("rr_ready0",  32'(bus.ext_ready),  32'd0);
        chk("rr_stall0",  32'(bus.core_stall), 32'd0);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("rr_post_stall", 32'(bus.core_stall), 32'd0);
        chk("rr_post_ready", 32'(bus.ext_ready),  32'd0);
        chk("rr_post_addr",  32'(bus.mem_addr),   32'h100);
        chk("rr_post_rdata", bus.core_rdata,      32'hDEAD_BEEF);
        next_cycle();
        idle();
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
